// File: rtl/cnn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cnn_pkg : shared constants, FSM state type and helpers for the     |
// | result-path packer.                          Revision: 1.0         |
// +--------------------------------------------------------------------+
package cnn_pkg;

    localparam int CFG_RLT_DEPTH = 20;
    localparam int CFG_RLT_COUNT = 21;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } rlt_state_t;

    function automatic int lanes_per_beat(input int str_w, input int img_w);
        return str_w / img_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_rlt_lane_sel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cnn_rlt_lane_sel : picks the channels of one output beat from the  |
// | held result word, zeroing channels at or beyond the active depth.  |
// |                                              Revision: 1.0         |
// +--------------------------------------------------------------------+
module cnn_rlt_lane_sel #(
    parameter int IMG_WIDTH     = 16,
    parameter int DEPTH_NB      = 16,
    parameter int STR_RLT_WIDTH = 64,
    parameter int BEAT_W        = 2,
    parameter int DEP_W         = 5
) (
    input  logic [IMG_WIDTH*DEPTH_NB-1:0] word_i,
    input  logic [BEAT_W-1:0]             beat_i,
    input  logic [DEP_W-1:0]              depth_i,
    output logic [STR_RLT_WIDTH-1:0]      beat_o
);
    import cnn_pkg::*;

    localparam int LANES = lanes_per_beat(STR_RLT_WIDTH, IMG_WIDTH);
    localparam int CH_W  = (DEPTH_NB > 1) ? $clog2(DEPTH_NB) : 1;

    logic [IMG_WIDTH-1:0] w_chan [DEPTH_NB];

    generate
        for (genvar k = 0; k < DEPTH_NB; k++) begin : g_chan
            assign w_chan[k] = word_i[k*IMG_WIDTH +: IMG_WIDTH];
        end

        for (genvar j = 0; j < LANES; j++) begin : g_lane
            logic [31:0]          w_ch;
            logic [IMG_WIDTH-1:0] w_lane;

            assign w_ch = 32'(beat_i) * 32'(LANES) + 32'(j);

            // The depth guard also covers lanes past the last physical channel.
            always_comb begin
                w_lane = '0;
                if (w_ch < 32'(depth_i) && w_ch < 32'(DEPTH_NB)) begin
                    w_lane = w_chan[w_ch[CH_W-1:0]];
                end
            end

            assign beat_o[j*IMG_WIDTH +: IMG_WIDTH] = w_lane;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/cnn_rlt_pack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cnn_rlt_pack : packs the first D channels of each result word into |
// | stream beats and flags the frame end after N words.                |
// | Optional macro CNN_RLT_RELU_EN rectifies channels at capture.      |
// |                                              Revision: 1.0         |
// +--------------------------------------------------------------------+
module cnn_rlt_pack #(
    parameter int CFG_DWIDTH    = 32,
    parameter int CFG_AWIDTH    = 5,
    parameter int IMG_WIDTH     = 16,
    parameter int DEPTH_NB      = 16,
    parameter int STR_RLT_WIDTH = 64,
    parameter int CFG_RLT_DEPTH = cnn_pkg::CFG_RLT_DEPTH,
    parameter int CFG_RLT_COUNT = cnn_pkg::CFG_RLT_COUNT,
    parameter int CNT_WIDTH     = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic [IMG_WIDTH*DEPTH_NB-1:0] result_bus,
    input  logic                          result_val,
    output logic                          result_rdy,
    output logic [STR_RLT_WIDTH-1:0]      str_rlt_bus,
    output logic                          str_rlt_last,
    output logic                          str_rlt_val,
    input  logic                          str_rlt_rdy,
    output logic [CNT_WIDTH-1:0]          frame_words
);
    import cnn_pkg::*;

    localparam int LANES     = lanes_per_beat(STR_RLT_WIDTH, IMG_WIDTH);
    localparam int MAX_BEATS = (DEPTH_NB + LANES - 1) / LANES;
    localparam int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int DEP_W     = $clog2(DEPTH_NB + 1);
    localparam int WORD_W    = IMG_WIDTH * DEPTH_NB;

    rlt_state_t            state_q;
    logic [WORD_W-1:0]     word_q;
    logic [DEP_W-1:0]      cfg_depth_q;
    logic [DEP_W-1:0]      depth_q;
    logic [DEP_W-1:0]      depth_d;
    logic [CNT_WIDTH-1:0]  cfg_count_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  frame_words_q;
    logic [CNT_WIDTH-1:0]  frame_words_d;
    logic [BEAT_W-1:0]     beat_q;
    logic [BEAT_W-1:0]     beats_m1_q;
    logic [BEAT_W-1:0]     beats_m1_d;

    logic [WORD_W-1:0]        w_cap_word;
    logic [STR_RLT_WIDTH-1:0] w_sel;
    logic [CNT_WIDTH-1:0]     w_fw_inc;
    logic                     w_depth_wr;
    logic                     w_count_wr;
    logic                     w_last_beat;
    logic                     w_beat_done;
    logic                     w_frame_hit;
    logic                     w_accept;

    assign w_depth_wr = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_RLT_DEPTH));
    assign w_count_wr = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_RLT_COUNT));

    always_comb begin
        depth_d = DEP_W'(DEPTH_NB);
        if (cfg_data != '0 && cfg_data <= CFG_DWIDTH'(DEPTH_NB)) begin
            depth_d = cfg_data[DEP_W-1:0];
        end
    end

    // Beat count derives from the live depth register because it is sampled at capture.
    assign beats_m1_d = BEAT_W'((32'(cfg_depth_q) + 32'(LANES) - 32'd1) / 32'(LANES) - 32'd1);

    assign w_last_beat = (state_q == SEND) && (beat_q == beats_m1_q);
    assign w_beat_done = w_last_beat && str_rlt_rdy;
    assign w_fw_inc    = frame_words_q + CNT_WIDTH'(1);
    assign w_frame_hit = (count_q != '0) && (w_fw_inc == count_q);
    assign frame_words_d = w_frame_hit ? '0 : w_fw_inc;

    assign result_rdy = (state_q == IDLE) || w_beat_done;
    assign w_accept   = result_val && result_rdy;

`ifdef CNN_RLT_RELU_EN
    generate
        for (genvar k = 0; k < DEPTH_NB; k++) begin : g_relu
            assign w_cap_word[k*IMG_WIDTH +: IMG_WIDTH] =
                result_bus[(k+1)*IMG_WIDTH-1] ? '0 : result_bus[k*IMG_WIDTH +: IMG_WIDTH];
        end
    endgenerate
`else
    assign w_cap_word = result_bus;
`endif

    cnn_rlt_lane_sel #(
        .IMG_WIDTH     (IMG_WIDTH),
        .DEPTH_NB      (DEPTH_NB),
        .STR_RLT_WIDTH (STR_RLT_WIDTH),
        .BEAT_W        (BEAT_W),
        .DEP_W         (DEP_W)
    ) u_lane_sel (
        .word_i  (word_q),
        .beat_i  (beat_q),
        .depth_i (depth_q),
        .beat_o  (w_sel)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            word_q        <= '0;
            cfg_depth_q   <= DEP_W'(DEPTH_NB);
            depth_q       <= DEP_W'(DEPTH_NB);
            cfg_count_q   <= '0;
            count_q       <= '0;
            frame_words_q <= '0;
            beat_q        <= '0;
            beats_m1_q    <= '0;
        end else begin
            if (w_depth_wr) begin
                cfg_depth_q <= depth_d;
            end
            if (w_count_wr) begin
                cfg_count_q <= CNT_WIDTH'(cfg_data);
            end

            if (w_accept) begin
                word_q     <= w_cap_word;
                depth_q    <= cfg_depth_q;
                count_q    <= cfg_count_q;
                beats_m1_q <= beats_m1_d;
                beat_q     <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (str_rlt_rdy) begin
                        if (beat_q == beats_m1_q) begin
                            if (!w_accept) begin
                                state_q <= IDLE;
                            end
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A count rewrite restarts the frame even if a word completes this cycle.
            if (w_count_wr) begin
                frame_words_q <= '0;
            end else if (w_beat_done) begin
                frame_words_q <= frame_words_d;
            end
        end
    end

    assign str_rlt_val  = (state_q == SEND);
    assign str_rlt_bus  = str_rlt_val ? w_sel : '0;
    assign str_rlt_last = w_last_beat && w_frame_hit;
    assign frame_words  = frame_words_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_rlt_pack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cnn_rlt_pack : cycle-table bench for the result-path packer.    |
// |                                              Revision: 1.0         |
// +--------------------------------------------------------------------+
module tb_cnn_rlt_pack;

    localparam logic       T  = 1'b1;
    localparam logic       F  = 1'b0;
    localparam logic [4:0] AD = 5'd20;
    localparam logic [4:0] AN = 5'd21;

    localparam logic [63:0] B0 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] B1 = 64'h0008_0007_0006_0005;
    localparam logic [63:0] B2 = 64'h000C_000B_000A_0009;
    localparam logic [63:0] B3 = 64'h0010_000F_000E_000D;
    localparam logic [63:0] P1 = 64'h0000_0000_0006_0005;
    localparam logic [63:0] D2 = 64'h0000_0000_0002_0001;
    localparam logic [63:0] Z  = 64'h0;

    typedef struct {
        logic        rst_n;
        logic        cfg_v;
        logic [4:0]  cfg_a;
        logic [31:0] cfg_d;
        logic        in_val;
        logic        in_rdy;
        logic        chk;
        logic        e_rrdy;
        logic        e_val;
        logic [63:0] e_bus;
        logic        e_last;
        logic [23:0] e_fw;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  cfg_data = '0;
    logic [4:0]   cfg_addr = '0;
    logic         cfg_valid = 1'b0;
    logic [255:0] result_bus = '0;
    logic         result_val = 1'b0;
    logic         result_rdy;
    logic [63:0]  str_rlt_bus;
    logic         str_rlt_last;
    logic         str_rlt_val;
    logic         str_rlt_rdy = 1'b0;
    logic [23:0]  frame_words;

    int   total = 0;
    int   bad   = 0;
    vec_t tab[$];

    cnn_rlt_pack dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_data     (cfg_data),
        .cfg_addr     (cfg_addr),
        .cfg_valid    (cfg_valid),
        .result_bus   (result_bus),
        .result_val   (result_val),
        .result_rdy   (result_rdy),
        .str_rlt_bus  (str_rlt_bus),
        .str_rlt_last (str_rlt_last),
        .str_rlt_val  (str_rlt_val),
        .str_rlt_rdy  (str_rlt_rdy),
        .frame_words  (frame_words)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rn, input logic cv, input logic [4:0] ca, input logic [31:0] cd,
                       input logic iv, input logic ir, input logic ck, input logic er, input logic ev,
                       input logic [63:0] eb, input logic el, input logic [23:0] ef);
        vec_t v;
        v.rst_n = rn; v.cfg_v = cv; v.cfg_a = ca; v.cfg_d = cd;
        v.in_val = iv; v.in_rdy = ir; v.chk = ck;
        v.e_rrdy = er; v.e_val = ev; v.e_bus = eb; v.e_last = el; v.e_fw = ef;
        tab.push_back(v);
    endtask

    task automatic r_rst();
        add(F, F, 5'd0, 32'd0, F, T, F, F, F, Z, F, 24'd0);
    endtask

    task automatic r_cfg(input logic [4:0] a, input logic [31:0] d);
        add(T, T, a, d, F, T, F, F, F, Z, F, 24'd0);
    endtask

    task automatic r_chk(input logic iv, input logic ir, input logic er, input logic ev,
                         input logic [63:0] eb, input logic el, input logic [23:0] ef);
        add(T, F, 5'd0, 32'd0, iv, ir, T, er, ev, eb, el, ef);
    endtask

    task automatic check(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    initial begin
        logic [255:0] w6;

        for (int k = 0; k < 16; k++) begin
            result_bus[k*16 +: 16] = 16'(k + 1);
        end

        // Full frame: D=16, N=2, two words back to back.
        r_rst(); r_cfg(AN, 32'd2);
        r_chk(T, T, T, F, Z,  F, 24'd0);
        r_chk(T, T, F, T, B0, F, 24'd0);
        r_chk(T, T, F, T, B1, F, 24'd0);
        r_chk(T, T, F, T, B2, F, 24'd0);
        r_chk(T, T, T, T, B3, F, 24'd0);
        r_chk(F, T, F, T, B0, F, 24'd1);
        r_chk(F, T, F, T, B1, F, 24'd1);
        r_chk(F, T, F, T, B2, F, 24'd1);
        r_chk(F, T, T, T, B3, T, 24'd1);
        r_chk(F, T, T, F, Z,  F, 24'd0);

        // Partial depth D=6.
        r_rst(); r_cfg(AD, 32'd6);
        r_chk(T, T, T, F, Z,  F, 24'd0);
        r_chk(F, T, F, T, B0, F, 24'd0);
        r_chk(F, T, T, T, P1, F, 24'd0);
        r_chk(F, T, T, F, Z,  F, 24'd1);

        // Depth clamps: 0 and 17 both behave as 16 channels.
        r_rst(); r_cfg(AD, 32'd0);
        r_chk(T, T, T, F, Z,  F, 24'd0);
        r_chk(F, T, F, T, B0, F, 24'd0);
        r_rst(); r_cfg(AD, 32'd17);
        r_chk(T, T, T, F, Z,  F, 24'd0);
        r_chk(F, T, F, T, B0, F, 24'd0);

        // Backpressure with N=1.
        r_rst(); r_cfg(AN, 32'd1);
        r_chk(T, T, T, F, Z,  F, 24'd0);
        r_chk(F, T, F, T, B0, F, 24'd0);
        r_chk(F, F, F, T, B1, F, 24'd0);
        r_chk(F, F, F, T, B1, F, 24'd0);
        r_chk(F, T, F, T, B1, F, 24'd0);
        r_chk(F, F, F, T, B2, F, 24'd0);
        r_chk(F, T, F, T, B2, F, 24'd0);
        r_chk(F, F, F, T, B3, T, 24'd0);
        r_chk(F, F, F, T, B3, T, 24'd0);
        r_chk(F, T, T, T, B3, T, 24'd0);
        r_chk(F, T, T, F, Z,  F, 24'd0);

        // Back-to-back single-beat words, D=4, N=0.
        r_rst(); r_cfg(AD, 32'd4);
        r_chk(T, T, T, F, Z, F, 24'd0);
        for (int k = 1; k < 8; k++) begin
            r_chk(T, T, T, T, B0, F, 24'(k - 1));
        end
        r_chk(F, T, T, T, B0, F, 24'd7);
        r_chk(F, T, T, F, Z,  F, 24'd8);

        // Depth rewrite during beat 1 only affects the following word.
        r_rst();
        r_chk(T, T, T, F, Z,  F, 24'd0);
        r_chk(F, T, F, T, B0, F, 24'd0);
        add(T, T, AD, 32'd2, F, T, T, F, T, B1, F, 24'd0);
        r_chk(F, T, F, T, B2, F, 24'd0);
        r_chk(T, T, T, T, B3, F, 24'd0);
        r_chk(F, T, T, T, D2, F, 24'd1);
        r_chk(F, T, T, F, Z,  F, 24'd2);

        // Reset in the middle of a word clears the held word and the frame count.
        r_rst(); r_cfg(AD, 32'd4);
        r_chk(T, T, T, F, Z,  F, 24'd0);
        r_chk(F, T, T, T, B0, F, 24'd0);
        r_chk(F, T, T, F, Z,  F, 24'd1);
        r_cfg(AD, 32'd16);
        r_chk(T, T, T, F, Z,  F, 24'd1);
        r_chk(F, T, F, T, B0, F, 24'd1);
        add(F, F, 5'd0, 32'd0, F, T, T, F, T, B1, F, 24'd1);
        r_chk(F, T, T, F, Z,  F, 24'd0);

        for (int i = 0; i < tab.size(); i++) begin
            @(posedge clk); #1;
            rst         = tab[i].rst_n;
            cfg_valid   = tab[i].cfg_v;
            cfg_addr    = tab[i].cfg_a;
            cfg_data    = tab[i].cfg_d;
            result_val  = tab[i].in_val;
            str_rlt_rdy = tab[i].in_rdy;
            #3;
            if (tab[i].chk) begin
                check("result_rdy",   i, 64'(result_rdy),   64'(tab[i].e_rrdy));
                check("str_rlt_val",  i, 64'(str_rlt_val),  64'(tab[i].e_val));
                check("str_rlt_bus",  i, str_rlt_bus,       tab[i].e_bus);
                check("str_rlt_last", i, 64'(str_rlt_last), 64'(tab[i].e_last));
                check("frame_words",  i, 64'(frame_words),  64'(tab[i].e_fw));
            end
        end

        // Rectification of negative channels at capture.
        w6 = result_bus;
        w6[15:0]  = 16'hFFF0;
        w6[31:16] = 16'h0010;
        @(posedge clk); #1;
        rst = 1'b0; cfg_valid = 1'b0; result_val = 1'b0; str_rlt_rdy = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; result_bus = w6; result_val = 1'b1;
        #3;
        check("relu_idle_rdy", -1, 64'(result_rdy), 64'd1);
        @(posedge clk); #1;
        result_val = 1'b0;
        #3;
        check("relu_val", -1, 64'(str_rlt_val), 64'd1);
`ifdef CNN_RLT_RELU_EN
        check("relu_beat0", -1, str_rlt_bus, 64'h0004_0003_0010_0000);
`else
        check("relu_beat0", -1, str_rlt_bus, 64'h0004_0003_0010_FFF0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
